// File: rtl/accelbrot_com_serializer.sv
// Word-serial transmitter. It accepts one wide operand per handshake and
// emits it as NWORDS words of WWIDTH bits, least-significant word first.
// q_start marks the first word of a frame and q_last marks the final word.
// A new operand can be accepted while the last word of the current frame is
// on q, so consecutive frames follow each other with no idle cycle.
module accelbrot_com_serializer #(
  parameter int WWIDTH = 34,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WWIDTH*NWORDS-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WWIDTH-1:0]        q,
  output logic                     q_start,
  output logic                     q_last,
  output logic                     q_valid
);

  localparam int DWIDTH = WWIDTH * NWORDS;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [DWIDTH-1:0]   sreg_q, sreg_d;
  logic [WWIDTH-1:0]   q_q, q_d;
  logic                q_start_q, q_start_d;
  logic                q_last_q, q_last_d;
  logic                q_valid_q, q_valid_d;

  logic                last_word;
  logic                accept;
  logic [IDXW-1:0]     idx_inc;

  // The last word of a frame is on q: a new operand may be taken this cycle.
  assign last_word = (state_q == SEND) && (idx_q == LAST_IDX);
  assign in_ready  = !rst && ((state_q == IDLE) || last_word);
  assign accept    = in_valid && in_ready;
  assign idx_inc   = idx_q + IDXW'(1);

  assign q       = q_q;
  assign q_start = q_start_q;
  assign q_last  = q_last_q;
  assign q_valid = q_valid_q;

  // Next-state: capture on accept, otherwise shift out the next unsent word.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sreg_d    = sreg_q;
    q_d       = '0;
    q_start_d = 1'b0;
    q_last_d  = 1'b0;
    q_valid_d = 1'b0;
    if (accept) begin
      // Word 0 goes straight to q; sreg keeps only the words still to send.
      state_d   = SEND;
      idx_d     = '0;
      sreg_d    = in_data >> WWIDTH;
      q_d       = in_data[WWIDTH-1:0];
      q_start_d = 1'b1;
      q_last_d  = (NWORDS == 1);
      q_valid_d = 1'b1;
    end else if ((state_q == SEND) && !last_word) begin
      idx_d     = idx_inc;
      sreg_d    = sreg_q >> WWIDTH;
      q_d       = sreg_q[WWIDTH-1:0];
      q_last_d  = (idx_inc == LAST_IDX);
      q_valid_d = 1'b1;
    end else if (state_q == SEND) begin
      // Frame finished and nothing new offered: drop back to idle.
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      q_q       <= '0;
      q_start_q <= 1'b0;
      q_last_q  <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      q_q       <= q_d;
      q_start_q <= q_start_d;
      q_last_q  <= q_last_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Operand shift register holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

endmodule
